// File: rtl/riscv_pkg.sv
// Shared RISC-V core widths and scalar types.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port: array mux, x0 forcing and optional write bypass.
module regfile_read_port
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = XLEN,
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned ADDR_WIDTH   = REG_ADDR_W,
  parameter bit          WRITE_BYPASS = 1'b0
) (
  input  logic [DATA_WIDTH-1:0] i_regs [NUM_REGS],
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_reg_write,
  input  logic [ADDR_WIDTH-1:0] i_addr_des,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic bypass_hit;

  assign bypass_hit = WRITE_BYPASS && i_reg_write && (i_addr_des == i_addr);

  always_comb begin
    o_data = i_regs[i_addr];
    // x0 wins over the bypass so a discarded write can never leak through.
    if (i_addr == '0) begin
      o_data = '0;
    end else if (bypass_hit) begin
      o_data = i_data;
    end
  end

endmodule

// File: rtl/register_file.sv
// Integer register file: 2 combinational read ports, 1 synchronous write port, x0 hardwired to zero.
module register_file
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = XLEN,
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned ADDR_WIDTH   = REG_ADDR_W,
  parameter bit          WRITE_BYPASS = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_reg_write,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [ADDR_WIDTH-1:0] i_addr_des,
  input  logic [ADDR_WIDTH-1:0] i_addr_srcA,
  input  logic [ADDR_WIDTH-1:0] i_addr_srcB,
  output logic [DATA_WIDTH-1:0] o_dataA,
  output logic [DATA_WIDTH-1:0] o_dataB
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Entry 0 is a constant; only x1..x(N-1) carry flops.
  assign regs[0] = '0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : gen_reg
    logic [DATA_WIDTH-1:0] reg_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        reg_q <= '0;
      end else if (i_reg_write && (i_addr_des == ADDR_WIDTH'(g))) begin
        reg_q <= i_data;
      end
    end

    assign regs[g] = reg_q;
  end

  regfile_read_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_REGS    (NUM_REGS),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .WRITE_BYPASS(WRITE_BYPASS)
  ) u_read_a (
    .i_regs     (regs),
    .i_addr     (i_addr_srcA),
    .i_reg_write(i_reg_write),
    .i_addr_des (i_addr_des),
    .i_data     (i_data),
    .o_data     (o_dataA)
  );

  regfile_read_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_REGS    (NUM_REGS),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .WRITE_BYPASS(WRITE_BYPASS)
  ) u_read_b (
    .i_regs     (regs),
    .i_addr     (i_addr_srcB),
    .i_reg_write(i_reg_write),
    .i_addr_des (i_addr_des),
    .i_data     (i_data),
    .o_data     (o_dataB)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: one instance without and one with write bypass, shared stimulus.
module tb_register_file;
  import riscv_pkg::*;

  logic      clk;
  logic      rst_n;
  logic      reg_write;
  xlen_t     data;
  reg_addr_t addr_des;
  reg_addr_t addr_a;
  reg_addr_t addr_b;
  xlen_t     a0, b0, a1, b1;

  int checks = 0;
  int errors = 0;

  register_file #(.WRITE_BYPASS(1'b0)) dut_nb (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_reg_write(reg_write),
    .i_data     (data),
    .i_addr_des (addr_des),
    .i_addr_srcA(addr_a),
    .i_addr_srcB(addr_b),
    .o_dataA    (a0),
    .o_dataB    (b0)
  );

  register_file #(.WRITE_BYPASS(1'b1)) dut_bp (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_reg_write(reg_write),
    .i_data     (data),
    .i_addr_des (addr_des),
    .i_addr_srcA(addr_a),
    .i_addr_srcB(addr_b),
    .o_dataA    (a1),
    .o_dataB    (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic      we;
    reg_addr_t des;
    xlen_t     wdata;
    reg_addr_t src_a;
    reg_addr_t src_b;
    xlen_t     exp_a;
    xlen_t     exp_b;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input xlen_t act, input xlen_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd0,  32'h1234_5678, 5'd0,  5'd0, 32'h0000_0000, 32'h0000_0000};
    vecs[1] = '{1'b1, 5'd1,  32'h8765_4321, 5'd1,  5'd0, 32'h8765_4321, 32'h0000_0000};
    vecs[2] = '{1'b1, 5'd2,  32'hABCD_EF01, 5'd2,  5'd1, 32'hABCD_EF01, 32'h8765_4321};
    vecs[3] = '{1'b1, 5'd3,  32'hAACC_EE01, 5'd3,  5'd3, 32'hAACC_EE01, 32'hAACC_EE01};
    vecs[4] = '{1'b1, 5'd4,  32'h1122_3344, 5'd4,  5'd2, 32'h1122_3344, 32'hABCD_EF01};
    vecs[5] = '{1'b0, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd4, 32'h0000_0000, 32'h1122_3344};
    vecs[6] = '{1'b0, 5'd1,  32'hFFFF_FFFF, 5'd1,  5'd0, 32'h8765_4321, 32'h0000_0000};
    vecs[7] = '{1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd3, 32'hCAFE_F00D, 32'hAACC_EE01};

    rst_n     = 1'b0;
    reg_write = 1'b0;
    data      = '0;
    addr_des  = '0;
    addr_a    = '0;
    addr_b    = '0;
    #10 rst_n = 1'b1;

    // Reset sweep: every address reads zero on both ports of both instances.
    for (int i = 0; i < 32; i++) begin
      addr_a = reg_addr_t'(i);
      addr_b = reg_addr_t'(31 - i);
      #1;
      check("rst_sweep_nb_a", a0, 32'h0);
      check("rst_sweep_nb_b", b0, 32'h0);
      check("rst_sweep_bp_a", a1, 32'h0);
      check("rst_sweep_bp_b", b1, 32'h0);
    end

    // Table: drive at negedge, check read-after-write just past the next rising edge.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      reg_write = vecs[i].we;
      addr_des  = vecs[i].des;
      data      = vecs[i].wdata;
      addr_a    = vecs[i].src_a;
      addr_b    = vecs[i].src_b;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_nb_a", i), a0, vecs[i].exp_a);
      check($sformatf("vec%0d_nb_b", i), b0, vecs[i].exp_b);
      check($sformatf("vec%0d_bp_a", i), a1, vecs[i].exp_a);
      check($sformatf("vec%0d_bp_b", i), b1, vecs[i].exp_b);
    end

    // Read-during-write on x3 (holding 0xAACCEE01).
    @(negedge clk);
    reg_write = 1'b1;
    addr_des  = 5'd3;
    data      = 32'h0F0F_0F0F;
    addr_a    = 5'd3;
    addr_b    = 5'd2;
    #1;
    check("rdw_pre_nb_a", a0, 32'hAACC_EE01);
    check("rdw_pre_bp_a", a1, 32'h0F0F_0F0F);
    check("rdw_pre_bp_b_other", b1, 32'hABCD_EF01);
    @(posedge clk);
    #1;
    check("rdw_post_nb_a", a0, 32'h0F0F_0F0F);
    check("rdw_post_bp_a", a1, 32'h0F0F_0F0F);

    // Bypass is gated by write enable and never applies to x0.
    @(negedge clk);
    reg_write = 1'b0;
    addr_des  = 5'd3;
    data      = 32'h1234_0000;
    addr_a    = 5'd3;
    addr_b    = 5'd0;
    #1;
    check("nobyp_we0_bp_a", a1, 32'h0F0F_0F0F);
    reg_write = 1'b1;
    addr_des  = 5'd0;
    data      = 32'h5555_5555;
    #1;
    check("byp_x0_bp_b", b1, 32'h0);
    check("byp_x0_nb_b", b0, 32'h0);

    // Async reset pulse between edges with x1..x4 loaded.
    @(negedge clk);
    reg_write = 1'b0;
    addr_a    = 5'd1;
    addr_b    = 5'd4;
    #1;
    check("pre_arst_nb_a", a0, 32'h8765_4321);
    check("pre_arst_nb_b", b0, 32'h1122_3344);
    #1 rst_n = 1'b0;
    #1;
    check("arst_nb_a", a0, 32'h0);
    check("arst_nb_b", b0, 32'h0);
    check("arst_bp_a", a1, 32'h0);
    check("arst_bp_b", b1, 32'h0);

    // Reset held across a rising edge beats a write.
    reg_write = 1'b1;
    addr_des  = 5'd2;
    data      = 32'h7777_7777;
    addr_a    = 5'd2;
    addr_b    = 5'd31;
    @(posedge clk);
    #1;
    check("rst_prio_nb_a", a0, 32'h0);
    @(negedge clk);
    reg_write = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_nb_a", a0, 32'h0);
    check("post_rst_nb_b", b0, 32'h0);
    check("post_rst_bp_b", b1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Integer register file for the RISC-V core: 32 registers × 32 bits, two combinational read ports (rs1/rs2) and one synchronous write port (rd).
- Sits in the decode/writeback path. Decode drives the source addresses; writeback drives the destination address, data and write enable.
- Register x0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- NUM_REGS, 32, number of architectural registers.
- ADDR_WIDTH, 5, address width; must equal clog2(NUM_REGS).
- WRITE_BYPASS, 0, when 1 a same-cycle write is forwarded to the read ports.

Ports:
- i_clk  in  1  clock, all state updates on the rising edge.
- i_rst_n  in  1  reset, active-low, asynchronous.
- i_reg_write  in  1  write enable for the destination port.
- i_data  in  DATA_WIDTH  write data.
- i_addr_des  in  ADDR_WIDTH  destination (rd) address.
- i_addr_srcA  in  ADDR_WIDTH  source A (rs1) address.
- i_addr_srcB  in  ADDR_WIDTH  source B (rs2) address.
- o_dataA  out  DATA_WIDTH  contents of register i_addr_srcA.
- o_dataB  out  DATA_WIDTH  contents of register i_addr_srcB.

Behaviour:
- Clocking and reset: one clock (i_clk); reset i_rst_n is asynchronous and active-low.
- Reset: asserting i_rst_n low immediately clears all NUM_REGS registers to 0, regardless of the clock.
  - With all registers cleared, o_dataA and o_dataB read 0.
  - Reset has priority over a write in the same cycle.
  - Reset asserted mid-operation discards all contents.
- Write:
  - On the rising edge of i_clk, with i_rst_n high and i_reg_write high, regs[i_addr_des] <= i_data.
  - The written value is visible on the read ports after that edge, so write latency is 1 edge.
- x0:
  - Writes with i_addr_des == 0 are ignored.
  - Register 0 always reads 0; no storage is required for it.
- Read:
  - Purely combinational, zero latency: o_dataA = regs[i_addr_srcA], o_dataB = regs[i_addr_srcB].
  - Both ports may address the same register simultaneously and both return its value.
- Simultaneous read and write of the same nonzero address in one cycle:
  - WRITE_BYPASS = 0: the read returns the old value until the edge.
  - WRITE_BYPASS = 1: the read returns i_data when i_reg_write is high. The bypass is never applied to address 0.
- i_reg_write low: no state change, whatever the values of i_data and i_addr_des.
- X-safety: the read outputs depend only on the addresses and stored state. No latches.

Decomposition:
- Shared package riscv_pkg:
  - Constants XLEN = 32 and REG_ADDR_W = 5.
  - Typedefs reg_addr_t (logic [4:0]) and xlen_t (logic [31:0]).
- Sub-module regfile_read_port, instantiated twice:
  - Performs the combinational read mux, x0 forcing and optional bypass for one port.
- Storage array and write logic stay in register_file.

Test Plan:
- Reset → both ports read 0 at every address. Apply reset low, release after 10 ns, then sweep srcA/srcB over 0..31.
- x0 write is discarded → srcA = 0 reads 0x00000000.
  - Stimulus: write 0x12345678 to address 0, then read srcA = 0.
- Sequential writes → both ports return the written values, and address 0 still reads 0.
  - Write 0x87654321 to address 1.
  - Write 0xABCDEF01 to address 2.
  - Write 0xAACCEE01 to address 3.
  - Write 0x11223344 to address 4.
  - Read all five addresses on srcA and srcB.
- Disabled write → address 5 still reads 0.
  - Stimulus: i_reg_write = 0 with i_data = 0xDEADBEEF, i_addr_des = 5, then read address 5.
- Read-during-write on address 3 (holding 0xAACCEE01) while writing 0x0F0F0F0F:
  - WRITE_BYPASS = 0: the read shows 0xAACCEE01 before the edge and 0x0F0F0F0F after it.
  - WRITE_BYPASS = 1: the read shows 0x0F0F0F0F immediately.
- Asynchronous reset mid-run → all outputs go to 0 without a clock edge.
  - Stimulus: with registers 1–4 loaded, pulse i_rst_n low between clock edges.
